// File: rtl/packet_deframer.sv
// Bit-serial packet deframer: hunts for a sync preamble, then collects
// indexed byte fields into slots and emits the packet once every slot is filled.
module packet_deframer #(
   parameter int                         PACKET_WIDTH    = 4,
   parameter int                         INDEX_WIDTH     = 2,
   parameter int                         PREAMBLE_LENGTH = 8,
   parameter logic [PREAMBLE_LENGTH-1:0] PREAMBLE        = 8'hD5,
   parameter int                         TIMEOUT         = 64
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      bit_in,
   input  logic                      bit_valid,
   output logic [8*PACKET_WIDTH-1:0] packet_out,
   output logic                      packet_valid,
   output logic                      err_index,
   output logic                      err_dup,
   output logic                      err_timeout,
   output logic                      locked
);

   localparam int FIELD_WIDTH = INDEX_WIDTH + 8;
   localparam int BIT_CNT_W   = $clog2(FIELD_WIDTH);
   localparam int FIELD_CNT_W = $clog2(PACKET_WIDTH + 1);
   localparam int IDLE_CNT_W  = $clog2(TIMEOUT + 1);

   typedef enum logic {HUNT, FIELD} state_t;

   state_t                    state, state_next;
   logic [PREAMBLE_LENGTH-1:0] pre_reg, hunt_shift;
   logic [FIELD_WIDTH-1:0]    field_reg, field_shift;
   logic [BIT_CNT_W-1:0]      bit_cnt;
   logic [FIELD_CNT_W-1:0]    field_cnt;
   logic [IDLE_CNT_W-1:0]     idle_cnt;
   logic [PACKET_WIDTH-1:0]   seen, seen_next;
   logic [8*PACKET_WIDTH-1:0] slots, slots_next;
   logic [31:0]               idx_ext;
   logic                      pre_hit, last_bit, idx_bad, seen_hit, dup;
   logic                      write_ok, done, timeout, leave_field;

   assign hunt_shift  = {pre_reg[PREAMBLE_LENGTH-2:0], bit_in};
   assign field_shift = {field_reg[FIELD_WIDTH-2:0], bit_in};
   assign idx_ext     = 32'(field_shift[FIELD_WIDTH-1:8]);

   assign pre_hit  = (state == HUNT) && bit_valid && (hunt_shift == PREAMBLE);
   assign last_bit = (state == FIELD) && bit_valid && (bit_cnt == BIT_CNT_W'(FIELD_WIDTH - 1));
   assign idx_bad  = last_bit && (idx_ext >= 32'(PACKET_WIDTH));
   assign dup      = last_bit && !idx_bad && seen_hit;
   assign write_ok = last_bit && !idx_bad && !seen_hit;
   assign done     = write_ok && (field_cnt == FIELD_CNT_W'(PACKET_WIDTH - 1));
   assign timeout  = (state == FIELD) && !bit_valid && (idle_cnt == IDLE_CNT_W'(TIMEOUT - 1));
   assign locked   = (state == FIELD);

   // NOTE: every variable written in an always_comb gets a default first so no latch is inferred.
   always_comb begin : seen_lookup
      seen_hit = 1'b0;
      for (int i = 0; i < PACKET_WIDTH; i++)
         if (idx_ext == 32'(i)) seen_hit = seen[i];
   end

   always_comb begin : slot_write
      slots_next = slots;
      seen_next  = seen;
      if (write_ok)
         for (int i = 0; i < PACKET_WIDTH; i++)
            if (idx_ext == 32'(i)) begin
               slots_next[8*i +: 8] = field_shift[7:0];
               seen_next[i]         = 1'b1;
            end
   end

   always_comb begin : next_state
      state_next = state;
      case (state)
         HUNT:    if (pre_hit) state_next = FIELD;
         FIELD:   if (idx_bad || dup || done || timeout) state_next = HUNT;
         default: state_next = HUNT;
      endcase
   end

   assign leave_field = (state == FIELD) && (state_next == HUNT);

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin : state_reg
      if (!rst_n) state <= HUNT;
      else        state <= state_next;
   end

   // NOTE: the slot storage is reset too, so an aborted-then-reset block never exposes stale bytes.
   always_ff @(posedge clk or negedge rst_n) begin : datapath
      if (!rst_n) begin
         pre_reg      <= '0;
         field_reg    <= '0;
         bit_cnt      <= '0;
         field_cnt    <= '0;
         idle_cnt     <= '0;
         seen         <= '0;
         slots        <= '0;
         packet_out   <= '0;
         packet_valid <= 1'b0;
         err_index    <= 1'b0;
         err_dup      <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         packet_valid <= done;
         err_index    <= idx_bad;
         err_dup      <= dup;
         err_timeout  <= timeout;
         if (state == HUNT) begin
            if (bit_valid) pre_reg <= hunt_shift;
            if (pre_hit) begin
               field_reg <= '0;
               bit_cnt   <= '0;
               field_cnt <= '0;
               idle_cnt  <= '0;
               seen      <= '0;
            end
         end else if (leave_field) begin
            // Hunting restarts from an empty window after any frame end.
            pre_reg <= '0;
            if (done) begin
               slots      <= slots_next;
               packet_out <= slots_next;
            end
         end else if (bit_valid) begin
            idle_cnt  <= '0;
            field_reg <= field_shift;
            bit_cnt   <= last_bit ? '0 : bit_cnt + 1'b1;
            if (write_ok) begin
               slots     <= slots_next;
               seen      <= seen_next;
               field_cnt <= field_cnt + 1'b1;
            end
         end else begin
            idle_cnt <= idle_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_packet_deframer.sv
// Directed bench for packet_deframer: two instances (4-byte and 3-byte packets)
// share one bit stream and are compared every cycle against a stream-level model.
module tb_packet_deframer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic bit_in = 1'b0;
   logic bit_valid = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] pkt4;
   logic [23:0] pkt3;
   logic        pv4, ei4, ed4, et4, lk4;
   logic        pv3, ei3, ed3, et3, lk3;

   packet_deframer dut4 (
      .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
      .packet_out(pkt4), .packet_valid(pv4), .err_index(ei4), .err_dup(ed4),
      .err_timeout(et4), .locked(lk4));

   packet_deframer #(.PACKET_WIDTH(3), .INDEX_WIDTH(2)) dut3 (
      .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
      .packet_out(pkt3), .packet_valid(pv3), .err_index(ei3), .err_dup(ed3),
      .err_timeout(et3), .locked(lk3));

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Stream-level model: instance 0 has 4 slots, instance 1 has 3.
   int          m_pw [2] = '{4, 3};
   bit          m_locked [2];
   int          m_pre [2], m_field [2], m_nbits [2], m_nf [2], m_idle [2];
   bit          m_seen [2][4];
   logic [7:0]  m_slot [2][4];
   logic [31:0] m_pkt [2];
   bit          e_pv [2], e_ei [2], e_ed [2], e_et [2];

   function automatic void m_reset(input int k);
      m_locked[k] = 0; m_pre[k] = 0; m_field[k] = 0; m_nbits[k] = 0;
      m_nf[k] = 0; m_idle[k] = 0; m_pkt[k] = '0;
      e_pv[k] = 0; e_ei[k] = 0; e_ed[k] = 0; e_et[k] = 0;
      for (int i = 0; i < 4; i++) begin m_seen[k][i] = 0; m_slot[k][i] = '0; end
   endfunction

   function automatic void m_step(input int k, input bit v, input bit b);
      int idx, data;
      e_pv[k] = 0; e_ei[k] = 0; e_ed[k] = 0; e_et[k] = 0;
      if (!m_locked[k]) begin
         if (v) begin
            m_pre[k] = ((m_pre[k] << 1) | int'(b)) & 255;
            if (m_pre[k] == 'hD5) begin
               m_locked[k] = 1; m_field[k] = 0; m_nbits[k] = 0; m_nf[k] = 0; m_idle[k] = 0;
               for (int i = 0; i < 4; i++) m_seen[k][i] = 0;
            end
         end
      end else if (v) begin
         m_idle[k]  = 0;
         m_field[k] = (m_field[k] << 1) | int'(b);
         m_nbits[k]++;
         if (m_nbits[k] == 10) begin
            idx = m_field[k] >> 8;
            data = m_field[k] & 255;
            m_field[k] = 0; m_nbits[k] = 0;
            if (idx >= m_pw[k]) begin
               e_ei[k] = 1; m_locked[k] = 0; m_pre[k] = 0;
            end else if (m_seen[k][idx]) begin
               e_ed[k] = 1; m_locked[k] = 0; m_pre[k] = 0;
            end else begin
               m_seen[k][idx] = 1; m_slot[k][idx] = data[7:0]; m_nf[k]++;
               if (m_nf[k] == m_pw[k]) begin
                  for (int i = 0; i < m_pw[k]; i++) m_pkt[k][8*i +: 8] = m_slot[k][i];
                  e_pv[k] = 1; m_locked[k] = 0; m_pre[k] = 0;
               end
            end
         end
      end else begin
         m_idle[k]++;
         if (m_idle[k] == 64) begin
            e_et[k] = 1; m_locked[k] = 0; m_pre[k] = 0;
         end
      end
   endfunction

   int cnt_pv [2], cnt_ei [2], cnt_ed [2], cnt_et [2];

   always @(negedge clk) begin : compare
      check("dut4 packet_valid", 32'(pv4), 32'(e_pv[0]));
      check("dut4 err_index",    32'(ei4), 32'(e_ei[0]));
      check("dut4 err_dup",      32'(ed4), 32'(e_ed[0]));
      check("dut4 err_timeout",  32'(et4), 32'(e_et[0]));
      check("dut4 locked",       32'(lk4), 32'(m_locked[0]));
      check("dut4 packet_out",   pkt4,     m_pkt[0]);
      check("dut3 packet_valid", 32'(pv3), 32'(e_pv[1]));
      check("dut3 err_index",    32'(ei3), 32'(e_ei[1]));
      check("dut3 err_dup",      32'(ed3), 32'(e_ed[1]));
      check("dut3 err_timeout",  32'(et3), 32'(e_et[1]));
      check("dut3 locked",       32'(lk3), 32'(m_locked[1]));
      check("dut3 packet_out",   32'(pkt3), m_pkt[1]);
      cnt_pv[0] += int'(pv4); cnt_ei[0] += int'(ei4); cnt_ed[0] += int'(ed4); cnt_et[0] += int'(et4);
      cnt_pv[1] += int'(pv3); cnt_ei[1] += int'(ei3); cnt_ed[1] += int'(ed3); cnt_et[1] += int'(et3);
   end

   task automatic clear_counts();
      for (int k = 0; k < 2; k++) begin cnt_pv[k] = 0; cnt_ei[k] = 0; cnt_ed[k] = 0; cnt_et[k] = 0; end
   endtask

   // One clock of stimulus; returns 1 ns after the following falling edge.
   task automatic cyc(input bit v, input bit b);
      bit_valid = v;
      bit_in    = b;
      @(posedge clk);
      if (rst_n) begin m_step(0, v, b); m_step(1, v, b); end
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 1'b0);
   endtask

   task automatic send_bits(input logic [9:0] val, input int n, input int gap);
      for (int i = n - 1; i >= 0; i--) begin
         cyc(1'b1, val[i]);
         if (gap > 0) idle(int'($urandom_range(0, gap)));
      end
   endtask

   task automatic send_pre(input int gap);
      send_bits(10'h0D5, 8, gap);
   endtask

   task automatic send_field(input logic [1:0] idx, input logic [7:0] d, input int gap);
      send_bits({idx, d}, 10, gap);
   endtask

   initial begin
      m_reset(0); m_reset(1);
      clear_counts();
      @(negedge clk); #1;
      check("reset locked", 32'(lk4), 32'd0);
      check("reset packet_out", pkt4, 32'h0);
      idle(1);
      rst_n = 1'b1;

      // Basic four-field frame delivered out of order.
      clear_counts();
      send_pre(0);
      send_field(2'd2, 8'hAA, 0);
      send_field(2'd0, 8'h11, 0);
      send_field(2'd3, 8'h33, 0);
      send_field(2'd1, 8'h22, 0);
      check("s1 packet_valid latency", 32'(pv4), 32'd1);
      check("s1 locked falls", 32'(lk4), 32'd0);
      check("s1 packet_out", pkt4, 32'h33AA2211);
      idle(3);
      check("s1 single packet pulse", 32'(cnt_pv[0]), 32'd1);
      check("s1 dut3 index error", 32'(cnt_ei[1]), 32'd1);

      // Duplicate slot after leading junk bits.
      clear_counts();
      cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
      send_pre(0);
      send_field(2'd0, 8'h01, 0);
      send_field(2'd0, 8'h02, 0);
      check("s2 err_dup pulse", 32'(ed4), 32'd1);
      check("s2 locked", 32'(lk4), 32'd0);
      check("s2 packet_out held", pkt4, 32'h33AA2211);
      idle(2);
      check("s2 no packet", 32'(cnt_pv[0]), 32'd0);

      // Three-field frame completes dut3; a fourth field completes dut4.
      send_pre(0);
      send_field(2'd2, 8'hC3, 0);
      send_field(2'd0, 8'hA5, 0);
      send_field(2'd1, 8'h5A, 0);
      check("s3 dut3 packet_valid", 32'(pv3), 32'd1);
      check("s3 dut3 packet_out", 32'(pkt3), 32'h00C35AA5);
      check("s3 dut4 still locked", 32'(lk4), 32'd1);
      send_field(2'd3, 8'h77, 0);
      check("s3 dut4 packet_out", pkt4, 32'h77C35AA5);

      // Out-of-range index on the 3-slot instance, then starvation on dut4.
      clear_counts();
      send_pre(0);
      send_field(2'd3, 8'hFF, 0);
      check("s4 dut3 err_index", 32'(ei3), 32'd1);
      check("s4 dut3 unlocked", 32'(lk3), 32'd0);
      check("s4 dut3 packet held", 32'(pkt3), 32'h00C35AA5);
      idle(63);
      check("s4 no timeout at 63", 32'(et4), 32'd0);
      check("s4 locked at 63", 32'(lk4), 32'd1);
      idle(1);
      check("s4 timeout at 64", 32'(et4), 32'd1);
      check("s4 unlocked after timeout", 32'(lk4), 32'd0);

      // Timeout on both instances, then a clean frame.
      clear_counts();
      send_pre(0);
      send_field(2'd1, 8'h55, 0);
      idle(64);
      check("s5 dut4 timeout count", 32'(cnt_et[0]), 32'd1);
      check("s5 dut3 timeout count", 32'(cnt_et[1]), 32'd1);
      send_pre(0);
      send_field(2'd1, 8'hBE, 0);
      send_field(2'd3, 8'hEF, 0);
      send_field(2'd0, 8'hAD, 0);
      send_field(2'd2, 8'hDE, 0);
      check("s5 packet_out", pkt4, 32'hEFDEBEAD);

      // Reset in the middle of a field, then a full frame.
      send_pre(0);
      send_bits(10'h015, 5, 0);
      bit_valid = 1'b1;
      rst_n = 1'b0;
      m_reset(0); m_reset(1);
      #1;
      check("s6 reset unlocks", 32'(lk4), 32'd0);
      check("s6 reset clears packet", pkt4, 32'h0);
      idle(2);
      rst_n = 1'b1;
      clear_counts();
      send_pre(0);
      send_field(2'd0, 8'h12, 0);
      send_field(2'd1, 8'h34, 0);
      send_field(2'd2, 8'h56, 0);
      send_field(2'd3, 8'h78, 0);
      idle(2);
      check("s6 packet_out", pkt4, 32'h78563412);
      check("s6 one packet", 32'(cnt_pv[0]), 32'd1);
      check("s6 no errors", 32'(cnt_ei[0] + cnt_ed[0] + cnt_et[0]), 32'd0);

      // Same frame as the first run with random idle gaps between bits.
      clear_counts();
      send_pre(10);
      send_field(2'd2, 8'hAA, 10);
      send_field(2'd0, 8'h11, 10);
      send_field(2'd3, 8'h33, 10);
      send_field(2'd1, 8'h22, 10);
      idle(2);
      check("s7 gapped packet_out", pkt4, 32'h33AA2211);
      check("s7 one packet", 32'(cnt_pv[0]), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/packet_deframer.md
PACKET_DEFRAMER -- requirements
Module: packet_deframer

Interface
REQ-001 SHALL have parameter PACKET_WIDTH, default 4, meaning the number of data bytes per packet.
REQ-002 SHALL have parameter INDEX_WIDTH, default 2, meaning the width of the per-byte slot index; INDEX_WIDTH >= clog2(PACKET_WIDTH).
REQ-003 SHALL have parameter PREAMBLE_LENGTH, default 8, meaning the preamble length in bits.
REQ-004 SHALL have parameter PREAMBLE, default 8'hD5, meaning the sync pattern, MSB first in time.
REQ-005 SHALL have parameter TIMEOUT, default 64, meaning the number of idle clk cycles between bits before a frame is aborted.
REQ-006 SHALL have port clk  input  1  meaning the single system clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_n  input  1  meaning an asynchronous, active-low reset.
REQ-008 SHALL have port bit_in  input  1  meaning the demodulated hard-decision bit.
REQ-009 SHALL have port bit_valid  input  1  meaning bit_in is sampled on this cycle.
REQ-010 SHALL have port packet_out  output  8*PACKET_WIDTH  meaning the reassembled packet; byte i is packet_out[8*i+7:8*i].
REQ-011 SHALL have port packet_valid  output  1  meaning a one-cycle pulse when packet_out is updated.
REQ-012 SHALL have port err_index  output  1  meaning a one-cycle pulse when a field index is >= PACKET_WIDTH.
REQ-013 SHALL have port err_dup  output  1  meaning a one-cycle pulse when a slot is written twice in one frame.
REQ-014 SHALL have port err_timeout  output  1  meaning a one-cycle pulse when a frame is aborted because of bit starvation.
REQ-015 SHALL have port locked  output  1  meaning the block is in state FIELD.

Function
REQ-016 SHALL implement states HUNT and FIELD, and leave both only on the events listed below.
REQ-017 In HUNT, each bit_valid SHALL shift bit_in into a PREAMBLE_LENGTH-bit register (new bit at LSB); when the updated register equals PREAMBLE, next state SHALL be FIELD with field and bit counters zeroed and the seen mask cleared.
REQ-018 In HUNT, the preamble register SHALL persist across idle cycles and be cleared on entry to HUNT.
REQ-019 In FIELD, bits SHALL be shifted MSB first into an (INDEX_WIDTH+8)-bit field register: index first, then data.
REQ-020 On the clk edge sampling the last bit of a field, idx >= PACKET_WIDTH SHALL pulse err_index on the next cycle and return to HUNT with no slot written.
REQ-021 On the same edge, if seen[idx] is already set, the block SHALL pulse err_dup on the next cycle and return to HUNT with no slot written.
REQ-022 On the same edge, if neither error applies, it SHALL write data into slot[idx], set seen[idx] and increment the field counter.
REQ-023 When the PACKET_WIDTH-th valid field is written, the block SHALL copy all slots to packet_out, assert packet_valid for exactly one cycle on the next cycle, and return to HUNT.
REQ-024 In FIELD, an idle counter SHALL reset on each bit_valid; reaching TIMEOUT SHALL pulse err_timeout and return to HUNT.
REQ-025 packet_out SHALL change only with packet_valid; aborted frames SHALL never alter it.
REQ-026 A bit_valid on the cycle the block returns to HUNT SHALL be consumed as the first HUNT bit.
REQ-027 At most one of packet_valid, err_index, err_dup and err_timeout SHALL be asserted in any cycle.
REQ-028 Latency SHALL be exactly 1 clk from the edge sampling the final data bit to packet_valid high.

Reset
REQ-029 rst_n low SHALL, asynchronously, force state HUNT and clear preamble register, counters, seen mask, slots and packet_out; packet_valid, all err_*, and locked SHALL be 0.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame with no output pulse.
REQ-031 After deassertion, the first bit_valid SHALL be processed on the next rising edge.

Verification
REQ-032 Preamble D5, then fields (2,AA),(0,11),(3,33),(1,22) -> packet_valid one cycle, packet_out=32'h33AA2211, locked falls the same cycle.
REQ-033 Bits 0,0,D5, then fields (0,01),(0,02) -> err_dup pulse after the second field, packet_out unchanged, locked=0.
REQ-034 PACKET_WIDTH=3, INDEX_WIDTH=2, preamble then field (3,FF) -> err_index pulse and return to HUNT.
REQ-035 Preamble plus one field, then bit_valid low for 64 cycles -> err_timeout on cycle 64; then a full valid frame -> correct packet.
REQ-036 rst_n pulsed low mid-field, then a full frame -> only that frame's packet_valid, no error pulses.
REQ-037 Random gaps of 0-10 idle cycles between bits of a valid frame -> same packet_out as the gap-free run.
